accumulate_driver: RTL

//  Upstream host-side stage for the synthesised accumulate kernel (module main).
//  - Takes a valid/ready word stream and writes it into the kernel's arr_a

---
 rtl/accumulate_driver.sv | 103 ++++++++++
 1 files changed

// File: rtl/accumulate_driver.sv
// accumulate_driver: streams words into the accumulate kernel's array, launches it and returns its result.
module accumulate_driver #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1000,
  parameter int TIMEOUT = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              run_only,
  input  logic [DATA_W-1:0] cfg_init_i,
  input  logic [DATA_W-1:0] cfg_init_acc,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_result,
  output logic              err_timeout,
  output logic              err_overflow,
  output logic              busy,
  output logic              controlArr,
  output logic              controlArrWEnable_a,
  output logic [ADDR_W-1:0] controlArrAddr_a,
  output logic [DATA_W-1:0] controlArrWData_a,
  output logic              r_enable,
  output logic [DATA_W-1:0] init_i,
  output logic [DATA_W-1:0] init_acc,
  input  logic              w_enable,
  input  logic [DATA_W-1:0] result
);
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, START, RUN, OUT} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       tmo_q, tmo_d;
  logic [DATA_W-1:0] init_i_q, init_acc_q, m_result_q;
  logic              err_tmo_q, err_ovf_q, in_load;
  assign in_load             = state_q == LOAD;
  assign tmo_d               = tmo_q + 32'd1;
  assign s_ready             = in_load | (state_q == DRAIN);
  assign controlArr          = in_load;
  assign controlArrWEnable_a = in_load & s_valid;
  assign controlArrAddr_a    = in_load ? addr_q : '0;
  assign controlArrWData_a   = in_load ? s_data : '0;
  assign r_enable            = state_q == START;
  assign m_valid             = state_q == OUT;
  assign busy                = state_q != IDLE;
  assign init_i              = init_i_q;
  assign init_acc            = init_acc_q;
  assign m_result            = m_result_q;
  assign err_timeout         = err_tmo_q;
  assign err_overflow        = err_ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      tmo_q      <= '0;
      init_i_q   <= '0;
      init_acc_q <= '0;
      m_result_q <= '0;
      err_tmo_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (s_valid || run_only) begin
          state_q    <= s_valid ? LOAD : START;
          init_i_q   <= cfg_init_i;
          init_acc_q <= cfg_init_acc;
          addr_q     <= '0;
          err_tmo_q  <= 1'b0;
          err_ovf_q  <= 1'b0;
        end
        LOAD: if (s_valid) begin
          addr_q <= addr_q + 1'b1;
          if (s_last) state_q <= START;
          else if (addr_q == ADDR_W'(DEPTH - 1)) begin
            state_q   <= DRAIN;
            err_ovf_q <= 1'b1;
          end
        end
        DRAIN: if (s_valid && s_last) state_q <= START;
        START: begin
          tmo_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          // a finishing kernel beats a timeout landing in the same cycle
          if (w_enable) begin
            m_result_q <= result;
            state_q    <= OUT;
          end else if (tmo_d == 32'(TIMEOUT - 1)) begin
            m_result_q <= '0;
            err_tmo_q  <= 1'b1;
            state_q    <= OUT;
          end else tmo_q <= tmo_d;
        end
        OUT: if (m_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
